// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM sequencer.
// Base writeback is compiled in only when LDM_STM_BASE_WB_EN is defined.
package lsm_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  PC_IDX     = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WB,
    ST_DONE
  } state_t;

  // Encoding matches {up, pre} so the mode is a direct cast.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_DB = 2'b01,
    MODE_IA = 2'b10,
    MODE_IB = 2'b11
  } mode_t;

  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) c = c + 5'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Memory request/ready port plus register-file read/write ports of the sequencer.
interface ldm_stm_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic [3:0]      rf_a1;
  logic [XLEN-1:0] rf_rd1;
  logic [3:0]      rf_a3;
  logic            rf_we3;
  logic [XLEN-1:0] rf_wd3;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output rf_a1,
    input  rf_rd1,
    output rf_a3, rf_we3, rf_wd3
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  rf_a1,
    output rf_rd1,
    input  rf_a3, rf_we3, rf_wd3
  );
endinterface

// File: rtl/ldm_stm_sequencer_lowest_set.sv
// Priority picker: index of the lowest set bit of a 16-bit register mask.
module lsm_lowest_set (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // Scan high to low so the lowest set bit is the final assignment.
    for (int unsigned i = 0; i < 16; i++) begin
      if (mask[15 - i]) begin
        idx = 4'(15 - i);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ldm_stm_sequencer.sv
// ARM-style LDM/STM sequencer: one register per memory transfer, R15 loads go to pc_we.
// Define LDM_STM_BASE_WB_EN to build the base-writeback (WB) state.
module ldm_stm_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 16,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_load,
  input  logic             up,
  input  logic             pre,
  input  logic             wb,
  input  logic [3:0]       rn,
  input  logic [XLEN-1:0]  base,
  input  logic [NREGS-1:0] reg_list,
  output logic             busy,
  output logic             done,
  output logic             pc_we,
  output logic [XLEN-1:0]  pc_wd,
  ldm_stm_sequencer_if.master bus
);
  import lsm_pkg::*;

  state_t           state_q, state_d;
  logic [NREGS-1:0] list_q, list_rest;
  logic [XLEN-1:0]  addr_q;
  logic             is_load_q;
  logic [3:0]       idx;
  logic             any;

  logic [4:0]       cnt;
  logic [XLEN-1:0]  span, start_addr;
  mode_t            mode;

`ifdef LDM_STM_BASE_WB_EN
  logic [XLEN-1:0]  final_q, final_addr;
  logic [3:0]       rn_q;
  logic             wb_en_q, wb_req;
`else
  logic [4:0]       unused_wb;
  assign unused_wb = {wb, rn};
`endif

  lsm_lowest_set u_lowest (
    .mask (list_q),
    .idx  (idx),
    .any  (any)
  );

  assign list_rest = list_q & ~(NREGS'(1) << idx);

  // Transfers always run upward from the lowest address of the block.
  always_comb begin
    cnt        = popcount16(reg_list);
    span       = XLEN'(cnt) * XLEN'(WORD_BYTES);
    mode       = mode_t'({up, pre});
    start_addr = base;
    unique case (mode)
      MODE_IA: start_addr = base;
      MODE_IB: start_addr = base + XLEN'(WORD_BYTES);
      MODE_DA: start_addr = base - span + XLEN'(WORD_BYTES);
      MODE_DB: start_addr = base - span;
    endcase
`ifdef LDM_STM_BASE_WB_EN
    final_addr = up ? base + span : base - span;
    wb_req     = wb && (cnt != '0) && !(is_load && reg_list[rn]) && (rn != PC_IDX);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      list_q    <= '0;
      addr_q    <= '0;
      is_load_q <= 1'b0;
`ifdef LDM_STM_BASE_WB_EN
      final_q   <= '0;
      rn_q      <= '0;
      wb_en_q   <= 1'b0;
`endif
    end else if (state_q == ST_IDLE && start) begin
      list_q    <= reg_list;
      addr_q    <= start_addr;
      is_load_q <= is_load;
`ifdef LDM_STM_BASE_WB_EN
      final_q   <= final_addr;
      rn_q      <= rn;
      wb_en_q   <= wb_req;
`endif
    end else if (state_q == ST_XFER && bus.mem_ready) begin
      list_q <= list_rest;
      addr_q <= addr_q + XLEN'(WORD_BYTES);
    end
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    pc_we         = 1'b0;
    pc_wd         = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rf_a1     = '0;
    bus.rf_a3     = '0;
    bus.rf_we3    = 1'b0;
    bus.rf_wd3    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (cnt == '0) ? ST_DONE : ST_XFER;
      end
      ST_XFER: begin
        busy         = 1'b1;
        bus.mem_req  = any;
        bus.mem_addr = addr_q;
        bus.mem_we   = !is_load_q;
        if (!is_load_q) begin
          bus.rf_a1     = idx;
          bus.mem_wdata = bus.rf_rd1;
        end
        if (!any) begin
          state_d = ST_DONE;
        end else if (bus.mem_ready) begin
          if (is_load_q && idx == PC_IDX) begin
            pc_we = 1'b1;
            pc_wd = bus.mem_rdata;
          end else if (is_load_q) begin
            bus.rf_we3 = 1'b1;
            bus.rf_a3  = idx;
            bus.rf_wd3 = bus.mem_rdata;
          end
          if (list_rest == '0) begin
`ifdef LDM_STM_BASE_WB_EN
            state_d = wb_en_q ? ST_WB : ST_DONE;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef LDM_STM_BASE_WB_EN
      ST_WB: begin
        busy       = 1'b1;
        bus.rf_we3 = 1'b1;
        bus.rf_a3  = rn_q;
        bus.rf_wd3 = final_q;
        state_d    = ST_DONE;
      end
`endif
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer with register-file and memory models.
module tb_ldm_stm_sequencer;

`ifdef LDM_STM_BASE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } xfer_t;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, is_load = 1'b0, up = 1'b0, pre = 1'b0, wb = 1'b0;
  logic [3:0]  rn = '0;
  logic [31:0] base = '0;
  logic [15:0] reg_list = '0;
  logic        busy, done, pc_we;
  logic [31:0] pc_wd;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [16];
  logic [31:0] mem [logic [31:0]];

  xfer_t       exp_x[$], obs_x[$];
  wr_t         exp_w[$], obs_w[$];
  logic [31:0] exp_pc[$], obs_pc[$];

  ldm_stm_sequencer_if #(.XLEN(32)) bus();

  ldm_stm_sequencer #(.XLEN(32), .NREGS(16), .WORD_BYTES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_load  (is_load),
    .up       (up),
    .pre      (pre),
    .wb       (wb),
    .rn       (rn),
    .base     (base),
    .reg_list (reg_list),
    .busy     (busy),
    .done     (done),
    .pc_we    (pc_we),
    .pc_wd    (pc_wd),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.rf_rd1 = rf[bus.rf_a1];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // One operation: build the expected transfer/write lists from the addressing rules,
  // run the DUT cycle by cycle, then compare.
  task automatic run_op(input bit ld, input bit u, input bit p, input bit w,
                        input logic [3:0] r, input logic [31:0] b, input logic [15:0] l,
                        input int pol, input bit poke, input string tag);
    int n, k, cyc, lowc, wcnt, done_cyc, busy_bad, stable_bad, idle_bad, exp_cyc;
    bit do_wb, rdy, held;
    logic [31:0] lo, fin, a, h_addr, h_wdata;
    logic [3:0] h_a1;
    logic h_we;

    exp_x.delete(); obs_x.delete(); exp_w.delete(); obs_w.delete();
    exp_pc.delete(); obs_pc.delete();
    n   = $countones(l);
    lo  = u ? (p ? b + 32'd4 : b) : (p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4);
    fin = u ? b + 32'(4 * n) : b - 32'(4 * n);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) begin
        a = lo + 32'(4 * k);
        k++;
        exp_x.push_back('{addr: a, we: !ld, data: (ld ? mem_val(a) : rf[i])});
        if (ld && i == 15) exp_pc.push_back(mem_val(a));
        else if (ld) exp_w.push_back('{a: 4'(i), d: mem_val(a)});
      end
    end
    do_wb = WB_EN && w && (n > 0) && !(ld && l[r]) && (r != 4'd15);
    if (do_wb) exp_w.push_back('{a: r, d: fin});

    @(negedge clk);
    is_load = ld; up = u; pre = p; wb = w; rn = r; base = b; reg_list = l; start = 1'b1;
    @(negedge clk);
    cyc = 1; lowc = 0; wcnt = 0; done_cyc = -1;
    busy_bad = 0; stable_bad = 0; held = 1'b0;
    h_addr = '0; h_wdata = '0; h_a1 = '0; h_we = 1'b0;
    while (cyc <= 300) begin
      start = poke && (cyc == 2);
      if (start) begin
        is_load = !ld; base = $urandom; reg_list = 16'hFFFF;
      end
      case (pol)
        0:       rdy = 1'b1;
        1:       rdy = (wcnt == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.mem_ready = rdy;
      bus.mem_rdata = mem_val(bus.mem_addr);
      #1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (held && (bus.mem_req !== 1'b1 || bus.mem_addr !== h_addr || bus.mem_we !== h_we ||
                   bus.mem_wdata !== h_wdata || bus.rf_a1 !== h_a1)) stable_bad++;
      if (bus.mem_req && !rdy) begin
        lowc++; wcnt++;
      end else begin
        wcnt = 0;
      end
      held = bus.mem_req && !rdy;
      h_addr = bus.mem_addr; h_we = bus.mem_we; h_wdata = bus.mem_wdata; h_a1 = bus.rf_a1;
      if (bus.mem_req && rdy) begin
        obs_x.push_back('{addr: bus.mem_addr, we: bus.mem_we,
                          data: (bus.mem_we ? bus.mem_wdata : bus.mem_rdata)});
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      end
      if (bus.rf_we3) begin
        obs_w.push_back('{a: bus.rf_a3, d: bus.rf_wd3});
        rf[bus.rf_a3] = bus.rf_wd3;
      end
      if (pc_we) obs_pc.push_back(pc_wd);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    exp_cyc = 1 + n + lowc + (do_wb ? 1 : 0);
    checks++;
    if (done_cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d (-1 = timeout)", tag, done_cyc, exp_cyc);
    end
    checks++;
    if (obs_x.size() != exp_x.size()) begin
      errors++;
      $display("FAIL %s xfer_count: got %0d want %0d", tag, obs_x.size(), exp_x.size());
    end else begin
      foreach (exp_x[i]) begin
        checks++;
        if (obs_x[i] !== exp_x[i]) begin
          errors++;
          $display("FAIL %s xfer[%0d]: got addr=%h we=%b data=%h want addr=%h we=%b data=%h",
                   tag, i, obs_x[i].addr, obs_x[i].we, obs_x[i].data,
                   exp_x[i].addr, exp_x[i].we, exp_x[i].data);
        end
      end
    end
    checks++;
    if (obs_w.size() != exp_w.size()) begin
      errors++;
      $display("FAIL %s rf_write_count: got %0d want %0d", tag, obs_w.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        checks++;
        if (obs_w[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL %s rf_write[%0d]: got R%0d=%h want R%0d=%h",
                   tag, i, obs_w[i].a, obs_w[i].d, exp_w[i].a, exp_w[i].d);
        end
      end
    end
    checks++;
    if (obs_pc.size() != exp_pc.size() || (exp_pc.size() == 1 && obs_pc[0] !== exp_pc[0])) begin
      errors++;
      $display("FAIL %s pc_write: got count=%0d first=%h want count=%0d first=%h", tag,
               obs_pc.size(), (obs_pc.size() > 0 ? obs_pc[0] : 32'h0),
               exp_pc.size(), (exp_pc.size() > 0 ? exp_pc[0] : 32'h0));
    end
    checks++;
    if (busy_bad != 0 || stable_bad != 0) begin
      errors++;
      $display("FAIL %s busy_hold: got busy_drops=%0d unstable=%0d want 0 and 0",
               tag, busy_bad, stable_bad);
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", tag, done, busy);
    end
    if (poke) begin
      idle_bad = 0;
      repeat (3) begin
        @(negedge clk); #1;
        if (busy !== 1'b0 || bus.mem_req !== 1'b0) idle_bad++;
      end
      checks++;
      if (idle_bad != 0) begin
        errors++;
        $display("FAIL %s start_while_busy: got %0d busy cycles want 0", tag, idle_bad);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, pc_we, bus.mem_req, bus.mem_we, bus.rf_we3} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, pc_we, bus.mem_req, bus.mem_we, bus.rf_we3});
    end
    checks++;
    if ({bus.mem_addr, bus.rf_a1, bus.rf_a3} !== 40'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 0", {bus.mem_addr, bus.rf_a1, bus.rf_a3});
    end
    checks++;
    if ({bus.mem_wdata, bus.rf_wd3, pc_wd} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {bus.mem_wdata, bus.rf_wd3, pc_wd});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stm_ia();
    rf[2] = 32'd42; rf[3] = 32'd77;
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h100, 16'h000C, 0, 1'b0, "stm_ia");
    checks++;
    if (mem[32'h100] !== 32'd42 || mem[32'h104] !== 32'd77) begin
      errors++;
      $display("FAIL stm_ia_mem: got %h %h want 0000002a 0000004d", mem[32'h100], mem[32'h104]);
    end
  endtask

  task automatic test_ldm_ib_pc();
    logic [31:0] r4_old, r15_old;
    mem[32'h204] = 32'd11; mem[32'h208] = 32'd22; mem[32'h20C] = 32'h400;
    r4_old = rf[4]; r15_old = rf[15];
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 32'h200, 16'h8006, 0, 1'b0, "ldm_ib_pc");
    checks++;
    if (rf[1] !== 32'd11 || rf[2] !== 32'd22 || rf[15] !== r15_old ||
        rf[4] !== (WB_EN ? 32'h20C : r4_old)) begin
      errors++;
      $display("FAIL ldm_ib_regs: got R1=%h R2=%h R4=%h R15=%h want 0000000b 00000016 %h %h",
               rf[1], rf[2], rf[4], rf[15], (WB_EN ? 32'h20C : r4_old), r15_old);
    end
  endtask

  task automatic test_stm_db_wait();
    logic [31:0] r5_old;
    rf[0] = 32'hCAFE_0000; rf[1] = 32'hCAFE_0001; r5_old = rf[5];
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h100, 16'h0003, 1, 1'b0, "stm_db_wait");
    checks++;
    if (mem[32'hF8] !== 32'hCAFE_0000 || mem[32'hFC] !== 32'hCAFE_0001 ||
        rf[5] !== (WB_EN ? 32'hF8 : r5_old)) begin
      errors++;
      $display("FAIL stm_db_result: got %h %h R5=%h want cafe0000 cafe0001 %h",
               mem[32'hF8], mem[32'hFC], rf[5], (WB_EN ? 32'hF8 : r5_old));
    end
  endtask

  task automatic test_empty_and_rn_in_list();
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h40, 16'h0000, 0, 1'b0, "empty_list");
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h300, 16'h0006, 0, 1'b1, "ldm_rn_in_list");
  endtask

  task automatic test_wrap();
    logic [31:0] r6_old;
    r6_old = rf[6];
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 32'hFFFF_FFFC, 16'h0003, 0, 1'b0, "wrap");
    checks++;
    if (rf[6] !== (WB_EN ? 32'h4 : r6_old)) begin
      errors++;
      $display("FAIL wrap_wb: got %h want %h", rf[6], (WB_EN ? 32'h4 : r6_old));
    end
  endtask

  task automatic test_reset_mid_op();
    int late;
    mem[32'h500] = 32'h1111_AAAA; mem[32'h504] = 32'h2222_BBBB;
    @(negedge clk);
    is_load = 1'b1; up = 1'b1; pre = 1'b0; wb = 1'b1; rn = 4'd9;
    base = 32'h500; reg_list = 16'h0007; start = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = mem_val(32'h500);
    #1;
    checks++;
    if (bus.rf_we3 !== 1'b1 || bus.rf_a3 !== 4'd0 || bus.rf_wd3 !== 32'h1111_AAAA) begin
      errors++;
      $display("FAIL rst_mid_first: got we=%b a3=%0d wd=%h want 1 0 1111aaaa",
               bus.rf_we3, bus.rf_a3, bus.rf_wd3);
    end
    if (bus.rf_we3) rf[bus.rf_a3] = bus.rf_wd3;
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.mem_rdata = mem_val(32'h504);
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h504) begin
      errors++;
      $display("FAIL rst_mid_second: got req=%b addr=%h want 1 00000504", bus.mem_req, bus.mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got req=%b busy=%b want 0 0", bus.mem_req, busy);
    end
    late = 0;
    repeat (2) begin
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      if (bus.rf_we3 || pc_we || bus.mem_req || busy) late++;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      if (bus.rf_we3 || pc_we || bus.mem_req || busy) late++;
    end
    bus.mem_ready = 1'b0;
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d active cycles want 0", late);
    end
  endtask

  task automatic test_random();
    logic [15:0] l;
    bit ld, pk;
    int pol;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      case ($urandom_range(0, 3))
        0:       l = 16'h0000;
        1:       l = 16'h0001 << $urandom_range(0, 15);
        2:       l = 16'($urandom) & 16'($urandom);
        default: l = 16'($urandom);
      endcase
      ld  = 1'($urandom);
      pol = $urandom_range(0, 2);
      pk  = ($countones(l) >= 2) && ($urandom_range(0, 1) == 1);
      run_op(ld, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
             $urandom, l, pol, pk, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + 32'(i);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_stm_ia();
    test_ldm_ib_pc();
    test_stm_db_wait();
    test_empty_and_rn_in_list();
    test_wrap();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
